// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: request handshake, response handshake and program-load port.
// master = the fetch requester / loader, slave = the fetch queue.
interface instr_fetch_queue_if #(
  parameter int REG_BITS = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [REG_BITS-1:0] req_pc;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [REG_BITS-1:0] rsp_instr;
  logic [REG_BITS-1:0] rsp_pc;
  logic [1:0]          rsp_fault;
  logic                load_en;
  logic [REG_BITS-1:0] load_addr;
  logic [7:0]          load_byte;

  modport master (
    output req_valid, req_pc, rsp_ready, load_en, load_addr, load_byte,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready, load_en, load_addr, load_byte,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: byte-addressed program memory, one-stage read pipeline
// and an in-order response FIFO with alignment / range fault reporting.
module instr_fetch_queue #(
  parameter int REG_BITS    = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int FIFO_DEPTH  = 3
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_queue_if.slave bus
);

  localparam int BYTES = REG_BITS / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  typedef struct packed {
    logic [1:0]          fault;
    logic [REG_BITS-1:0] instr;
    logic [REG_BITS-1:0] pc;
  } rsp_t;

  // Misalignment is checked first so it wins over the range fault.
  function automatic logic [1:0] classify(input logic [REG_BITS-1:0] pc);
    logic [REG_BITS:0] last;
    last = {1'b0, pc} + (REG_BITS+1)'(BYTES - 1);
    if (pc[OFS_W-1:0] != '0)
      return FAULT_ALIGN;
    if (64'(last) >= 64'(DEPTH_BYTES))
      return FAULT_RANGE;
    return FAULT_OK;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [7:0]    mem [DEPTH_BYTES];
  rsp_t          fifo [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;

  logic          accept;
  logic          load_hit;
  logic          push;
  logic          pop;
  logic          rsp_valid;
  logic [AW-1:0] rd_base;
  rsp_t          rd_rsp;
  rsp_t          head;

  logic          vld_p0;
  rsp_t          rsp_p0;

  // Occupancy counts the read in flight so the FIFO can never overflow.
  assign occ           = {1'b0, count} + {{CW{1'b0}}, vld_p0};
  assign bus.req_ready = occ < (CW+1)'(FIFO_DEPTH);

  assign accept   = bus.req_valid & bus.req_ready & ~reset;
  assign load_hit = bus.load_en & ~reset & (64'(bus.load_addr) < 64'(DEPTH_BYTES));
  assign rd_base  = bus.req_pc[AW-1:0];

  // Stage p0 input: combinational read of the old memory contents (read-first)
  always_comb begin
    rd_rsp.pc    = bus.req_pc;
    rd_rsp.fault = classify(bus.req_pc);
    rd_rsp.instr = '0;
    if (rd_rsp.fault == FAULT_OK) begin
      for (int i = 0; i < BYTES; i++)
        rd_rsp.instr[REG_BITS-1-8*i -: 8] = mem[rd_base + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (load_hit)
      mem[bus.load_addr[AW-1:0]] <= bus.load_byte;
  end

  // Stage p0: read in flight, pushed into the FIFO on the next edge
  always_ff @(posedge clk) begin
    if (reset)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept)
      rsp_p0 <= rd_rsp;
  end

  // Response FIFO
  assign rsp_valid = (count != '0);
  assign push      = vld_p0;
  assign pop       = rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= rsp_p0;
  end

  // Outputs read as zero whenever the queue is empty, including straight after reset.
  assign head          = fifo[rd_ptr];
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_instr = rsp_valid ? head.instr : '0;
  assign bus.rsp_pc    = rsp_valid ? head.pc    : '0;
  assign bus.rsp_fault = rsp_valid ? head.fault : FAULT_OK;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a 32-bit and a 16-bit instance share one stimulus
// stream; a reference model fills per-instance scoreboards that a monitor drains.
module tb_instr_fetch_queue;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        rsp_ready;
  logic        load_en;
  logic [31:0] load_addr;
  logic [7:0]  load_byte;

  always #5 clk = ~clk;

  instr_fetch_queue_if #(.REG_BITS(32)) bus32 ();
  instr_fetch_queue_if #(.REG_BITS(16)) bus16 ();

  instr_fetch_queue #(.REG_BITS(32), .DEPTH_BYTES(DEPTH), .FIFO_DEPTH(3)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32)
  );
  instr_fetch_queue #(.REG_BITS(16), .DEPTH_BYTES(DEPTH), .FIFO_DEPTH(3)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  assign bus32.req_valid = req_valid;
  assign bus32.req_pc    = req_pc;
  assign bus32.rsp_ready = rsp_ready;
  assign bus32.load_en   = load_en;
  assign bus32.load_addr = load_addr;
  assign bus32.load_byte = load_byte;
  assign bus16.req_valid = req_valid;
  assign bus16.req_pc    = req_pc[15:0];
  assign bus16.rsp_ready = rsp_ready;
  assign bus16.load_en   = load_en;
  assign bus16.load_addr = load_addr[15:0];
  assign bus16.load_byte = load_byte;

  logic [1:0]        v, rdy;
  logic [1:0][31:0]  oi, op;
  logic [1:0][1:0]   of;
  logic [1:0][65:0]  cur, held;
  logic [1:0]        stall_prev;

  assign v[0]  = bus32.rsp_valid;
  assign v[1]  = bus16.rsp_valid;
  assign rdy[0] = bus32.req_ready;
  assign rdy[1] = bus16.req_ready;
  assign oi[0] = bus32.rsp_instr;
  assign oi[1] = {16'h0, bus16.rsp_instr};
  assign op[0] = bus32.rsp_pc;
  assign op[1] = {16'h0, bus16.rsp_pc};
  assign of[0] = bus32.rsp_fault;
  assign of[1] = bus16.rsp_fault;
  assign cur[0] = {of[0], oi[0], op[0]};
  assign cur[1] = {of[1], oi[1], op[1]};

  logic [7:0] mem_m [DEPTH];
  rsp_t exp0[$], exp1[$], log0[$], log1[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Reference: fault rules first, then big-endian byte concatenation.
  function automatic rsp_t model_fetch(input int nb, input logic [31:0] pc, input int c);
    rsp_t e;
    e.pc = pc; e.instr = 32'h0; e.fault = 2'b00; e.cyc = c;
    if (pc % nb != 0)
      e.fault = 2'b01;
    else if (longint'(pc) + nb > DEPTH)
      e.fault = 2'b10;
    else
      for (int i = 0; i < nb; i++)
        e.instr = (e.instr << 8) | 32'(mem_m[pc + i]);
    return e;
  endfunction

  // Model: expected responses are queued at acceptance, loads applied after the read.
  always @(negedge clk) begin
    if (reset) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (req_valid && rdy[0]) exp0.push_back(model_fetch(4, req_pc, cyc));
      if (req_valid && rdy[1]) exp1.push_back(model_fetch(2, {16'h0, req_pc[15:0]}, cyc));
      if (load_en && load_addr < DEPTH) mem_m[load_addr[7:0]] <= load_byte;
    end
  end

  task automatic pop_compare(input int k);
    rsp_t e, a;
    a.instr = oi[k]; a.pc = op[k]; a.fault = of[k]; a.cyc = cyc;
    if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
      check(k == 0 ? "rsp32_pending" : "rsp16_pending", 0, 1);
    end else begin
      if (k == 0) begin e = exp0.pop_front(); log0.push_back(a); end
      else        begin e = exp1.pop_front(); log1.push_back(a); end
      check(k == 0 ? "rsp32" : "rsp16", {a.fault, a.instr, a.pc}, {e.fault, e.instr, e.pc});
      check(k == 0 ? "rsp32_latency" : "rsp16_latency", a.cyc >= e.cyc + 1, 1);
    end
  endtask

  // Monitor: pops on each handshake and checks outputs hold while stalled.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        stall_prev[k] <= 1'b0;
      end else if (v[k]) begin
        if (stall_prev[k]) check(k == 0 ? "hold32" : "hold16", cur[k], held[k]);
        if (rsp_ready) pop_compare(k);
        stall_prev[k] <= !rsp_ready;
        held[k]       <= cur[k];
      end else begin
        if (stall_prev[k]) check(k == 0 ? "hold32_valid" : "hold16_valid", v[k], 1);
        stall_prev[k] <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [7:0] b);
    load_en = 1'b1; load_addr = a; load_byte = b;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_accept();
    bit done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (rdy[0]) done = 1;
      tick();
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic fetch(input logic [31:0] pc);
    req_valid = 1'b1; req_pc = pc;
    wait_accept();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp0.size() == 0 && exp1.size() == 0 && !v[0] && !v[1]) done = 1;
      tick();
    end
    check("drain_done", done, 1);
  endtask

  task automatic check_log(input int k, input int idx, input string name,
                           input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] fault);
    rsp_t a;
    int sz;
    sz = (k == 0) ? log0.size() : log1.size();
    if (idx >= sz) begin
      check({name, "_present"}, 0, 1);
    end else begin
      a = (k == 0) ? log0[idx] : log1[idx];
      check(name, {a.fault, a.instr, a.pc}, {fault, instr, pc});
    end
  endtask

  task automatic check_pc(input int idx, input string name, input logic [31:0] pc);
    if (idx >= log0.size()) check({name, "_present"}, 0, 1);
    else                    check(name, log0[idx].pc, pc);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, {rdy, v, oi, op, of}, {2'b11, 2'b00, 64'h0, 64'h0, 4'h0});
    tick();
  endtask

  int n0, n1, acc;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_byte = '0;
    tick(); tick();
    reset = 1'b0;
    check_idle("reset_state");

    for (int a = 0; a < DEPTH; a++) load(a, 8'($urandom));
    load(DEPTH + 44, 8'h77);
    load(DEPTH, 8'h66);
    rsp_ready = 1'b1;
    fetch(44);
    fetch(0);
    drain();

    // Back-to-back fetches, one response per cycle
    for (int a = 0; a < 4; a++) load(a, 8'hF0);
    for (int a = 4; a < 8; a++) load(a, 8'h0F);
    n0 = log0.size();
    fetch(0);
    fetch(4);
    drain();
    check_log(0, n0,     "be32_pc0", 32'hF0F0F0F0, 32'd0, 2'b00);
    check_log(0, n0 + 1, "be32_pc4", 32'h0F0F0F0F, 32'd4, 2'b00);
    if (log0.size() >= n0 + 2) check("be32_gap", log0[n0 + 1].cyc - log0[n0].cyc, 1);
    else                       check("be32_gap_present", 0, 1);

    load(0, 8'hF0); load(1, 8'hF0); load(2, 8'h0F); load(3, 8'h0F);
    n0 = log0.size(); n1 = log1.size();
    fetch(0);
    fetch(2);
    drain();
    check_log(1, n1,     "be16_pc0", 32'h0000F0F0, 32'd0, 2'b00);
    check_log(1, n1 + 1, "be16_pc2", 32'h00000F0F, 32'd2, 2'b00);
    check_log(0, n0 + 1, "misalign32_pc2", 32'h0, 32'd2, 2'b01);

    n0 = log0.size();
    fetch(254);
    fetch(252);
    fetch(256);
    drain();
    check_log(0, n0, "misalign32_pc254", 32'h0, 32'd254, 2'b01);
    if (log0.size() > n0 + 1) check("valid32_pc252_fault", log0[n0 + 1].fault, 2'b00);
    else                      check("valid32_pc252_present", 0, 1);
    check_log(0, n0 + 2, "range32_pc256", 32'h0, 32'd256, 2'b10);

    // Stall: three accepts fill the queue, then back-pressure
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h20; acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy[0]) acc++;
      tick();
      req_pc = 32'h20 + 32'(4 * acc);
    end
    check("stall_accepts", acc, 3);
    @(negedge clk);
    check("stall_ready_low", rdy, 2'b00);
    tick();
    req_valid = 1'b0;
    n0 = log0.size();
    drain();
    check_pc(n0,     "stall_order0", 32'h20);
    check_pc(n0 + 1, "stall_order1", 32'h24);
    check_pc(n0 + 2, "stall_order2", 32'h28);

    // Load and fetch on the same edge return the old byte
    for (int a = 0; a < 4; a++) load(a, 8'hF0);
    n0 = log0.size();
    load_en = 1'b1; load_addr = 0; load_byte = 8'hAA;
    req_valid = 1'b1; req_pc = 0;
    wait_accept();
    load_en = 1'b0; req_valid = 1'b0;
    fetch(0);
    drain();
    check_log(0, n0,     "readfirst_old", 32'hF0F0F0F0, 32'd0, 2'b00);
    check_log(0, n0 + 1, "readfirst_new", 32'hAAF0F0F0, 32'd0, 2'b00);

    // Reset the cycle after an accept discards the in-flight read
    load(0, 8'hF0);
    n0 = log0.size(); n1 = log1.size();
    fetch(0);
    reset = 1'b1; load_en = 1'b1; load_addr = 0; load_byte = 8'h55;
    req_valid = 1'b1; req_pc = 4;
    tick();
    reset = 1'b0; load_en = 1'b0; req_valid = 1'b0;
    check_idle("post_reset_state");
    repeat (5) tick();
    check("reset_discard32", log0.size(), n0);
    check("reset_discard16", log1.size(), n1);
    fetch(0);
    drain();
    check_log(0, n0, "mem_kept", 32'hF0F0F0F0, 32'd0, 2'b00);

    // Randomised traffic, including occasional resets
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_pc    = ($urandom_range(0, 7) < 6) ? 32'($urandom_range(0, 63) * 4)
                                             : 32'($urandom_range(0, 299));
      rsp_ready = ($urandom_range(0, 3) != 0);
      load_en   = ($urandom_range(0, 7) == 0);
      load_addr = 32'($urandom_range(0, 299));
      load_byte = 8'($urandom);
      reset     = ($urandom_range(0, 127) == 0);
      tick();
    end
    reset = 1'b0; req_valid = 1'b0; load_en = 1'b0;
    drain();
    check("final_empty", {32'(exp0.size()), 32'(exp1.size())}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter REG_BITS, default 32: instruction/PC width; only 16 and 32 legal.
REQ-002 SHALL have parameter DEPTH_BYTES, default 256: byte-addressed memory size; power of two, at least 8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 3: response queue entries; minimum 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1: fetch request present.
REQ-007 SHALL have port req_ready, output, 1: request can be accepted.
REQ-008 SHALL have port req_pc, input, REG_BITS: byte address of the fetch.
REQ-009 SHALL have port rsp_valid, output, 1: queue head holds a response.
REQ-010 SHALL have port rsp_ready, input, 1: consumer takes the head.
REQ-011 SHALL have port rsp_instr, output, REG_BITS: fetched instruction.
REQ-012 SHALL have port rsp_pc, output, REG_BITS: PC of the head response.
REQ-013 SHALL have port rsp_fault, output, 2: 00 ok, 01 misaligned, 10 out of range.
REQ-014 SHALL have port load_en, input, 1: program-load byte write strobe.
REQ-015 SHALL have port load_addr, input, REG_BITS: byte address of the write.
REQ-016 SHALL have port load_byte, input, 8: data of the write.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL make req_ready a registered-state function only: 1 iff (queued entries + in-flight reads) < FIFO_DEPTH, with no combinational path from rsp_ready or req_valid.
REQ-019 SHALL read memory in the accept cycle and push the result into the queue on the following edge: 1-cycle latency, so rsp_valid rises no earlier than the cycle after acceptance.
REQ-020 SHALL assemble the instruction big-endian: byte mem[pc] occupies bits [REG_BITS-1:REG_BITS-8], and mem[pc+REG_BITS/8-1] occupies bits [7:0].
REQ-021 SHALL flag fault 01, with rsp_instr 0, when pc is not a multiple of REG_BITS/8.
REQ-022 SHALL flag fault 10, with rsp_instr 0, when pc+REG_BITS/8-1 >= DEPTH_BYTES and pc is aligned; misalignment takes precedence.
REQ-023 SHALL return responses strictly in acceptance order, never dropping or duplicating one.
REQ-024 SHALL pop the head on an edge where rsp_valid and rsp_ready are both 1; pop and push in the same edge leave the count unchanged.
REQ-025 SHALL hold rsp_instr, rsp_pc and rsp_fault stable while rsp_valid=1 and rsp_ready=0.
REQ-026 SHALL sustain one accept and one pop per cycle with rsp_ready held at 1 when FIFO_DEPTH >= 3.
REQ-027 SHALL write load_byte to mem[load_addr] on an edge where load_en=1 and load_addr < DEPTH_BYTES; out-of-range writes are ignored silently.
REQ-028 SHALL be read-first: a fetch accepted in the same cycle as a load to one of its bytes returns the old byte.
REQ-029 SHALL wrap the queue read and write pointers modulo FIFO_DEPTH without loss at wrap.

Reset
REQ-030 SHALL, on an edge with reset=1, clear the queue and in-flight read, and drive rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_fault=00, req_ready=1 the next cycle.
REQ-031 SHALL discard a read in flight at reset; no response for it ever appears.
REQ-032 SHALL not modify memory contents on reset, and SHALL ignore load_en and req_valid during reset.

Verification
REQ-033 SHALL cover: with REG_BITS=32, load bytes 0-3 = F0 and bytes 4-7 = 0F, fetch pc 0 then 4 back-to-back with rsp_ready=1 -> F0F0F0F0 (rsp_pc 0) then 0F0F0F0F (rsp_pc 4), both fault 00, one cycle apart.
REQ-034 SHALL cover: with REG_BITS=16, bytes 0-3 = F0,F0,0F,0F, fetch pc 0 and 2 -> F0F0, then 0F0F.
REQ-035 SHALL cover: pc 2 with REG_BITS=32 -> fault 01, instr 0; pc 254 with DEPTH_BYTES=256, REG_BITS=32 -> fault 01; pc 252 valid; pc 256 -> fault 10.
REQ-036 SHALL cover: rsp_ready=0 with req_valid=1 held -> exactly 3 accepts and then req_ready=0; raising rsp_ready drains the queue in order with outputs stable while stalled.
REQ-037 SHALL cover: a load of 0xAA to byte 0 in the same cycle as an accepted fetch of pc 0 -> old F0F0F0F0 returned; the next fetch of pc 0 -> AAF0F0F0.
REQ-038 SHALL cover: reset asserted the cycle after accept -> no rsp_valid for that request, req_ready=1 after reset, memory still returns F0F0F0F0 for pc 0.
